// File: rtl/frame_fifo_feeder.sv
// frame_fifo_feeder: accepts a framed pixel stream and writes exactly-sized
// frames into the output FIFO. Short frames are passed through and counted.
// Long frames are truncated at width*height and the rest is drained.
// Input stops after num_frame frames (0 = run forever).
module frame_fifo_feeder #(
    parameter int DWIDTH = 24
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [10:0]       width,
    input  logic [10:0]       height,
    input  logic [10:0]       num_frame,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_sop,
    input  logic              in_eop,
    output logic              fifo_wrreq,
    output logic [DWIDTH-1:0] fifo_data,
    input  logic              fifo_full,
    output logic [10:0]       frame_cnt,
    output logic [7:0]        short_err_cnt,
    output logic [7:0]        long_err_cnt,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [21:0] pix_cnt_q, pix_cnt_d;
    logic [21:0] frame_size_q, frame_size_d;
    logic [10:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  short_err_q, short_err_d;
    logic [7:0]  long_err_q, long_err_d;
    logic        done_q, done_d;

    logic        ready_raw;
    logic        accept;
    logic        write_beat;
    logic [21:0] sof_size;
    logic [21:0] pix_next;
    logic [1:0]  frame_inc;
    logic [1:0]  short_inc;
    logic        long_inc;

    // Saturating add for the 8-bit error counters; one beat can add at most 2.
    function automatic logic [7:0] sat_add8(input logic [7:0] cnt, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    assign sof_size = 22'(width) * 22'(height);
    assign pix_next = pix_cnt_q + 22'd1;

    // Ready is combinational from FIFO back-pressure. A SOF beat seen while
    // draining is written to the FIFO, so it waits for space like any other
    // written beat; non-SOF drain beats are always swallowed.
    always_comb begin
        ready_raw = 1'b0;
        case (state_q)
            ST_IDLE, ST_ACTIVE: ready_raw = !fifo_full;
            ST_DRAIN:           ready_raw = !(in_sop && fifo_full);
            default:            ready_raw = 1'b0;
        endcase
    end

    assign in_ready   = ready_raw && !reset;
    assign accept     = in_valid && in_ready;
    assign fifo_wrreq = accept && write_beat;
    assign fifo_data  = in_data;

    // Frame tracking: decides per accepted beat whether it is written, where
    // the frame ends, and which counters move.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d      = state_q;
        pix_cnt_d    = pix_cnt_q;
        frame_size_d = frame_size_q;
        write_beat   = 1'b0;
        frame_inc    = 2'd0;
        short_inc    = 2'd0;
        long_inc     = 1'b0;

        if (accept) begin
            if (in_sop) begin
                // A SOF inside a frame closes the previous one as short.
                if (state_q == ST_ACTIVE) begin
                    frame_inc = frame_inc + 2'd1;
                    short_inc = short_inc + 2'd1;
                end
                frame_size_d = sof_size;
                if (sof_size == 22'd0) begin
                    // Zero-sized frame: nothing written, rest of frame dropped.
                    long_inc  = 1'b1;
                    frame_inc = frame_inc + 2'd1;
                    state_d   = in_eop ? ST_IDLE : ST_DRAIN;
                end else begin
                    write_beat = 1'b1;
                    pix_cnt_d  = 22'd1;
                    if (sof_size == 22'd1) begin
                        // First pixel is also the last expected one.
                        frame_inc = frame_inc + 2'd1;
                        if (in_eop) begin
                            state_d = ST_IDLE;
                        end else begin
                            long_inc = 1'b1;
                            state_d  = ST_DRAIN;
                        end
                    end else if (in_eop) begin
                        short_inc = short_inc + 2'd1;
                        frame_inc = frame_inc + 2'd1;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end
            end else begin
                case (state_q)
                    ST_ACTIVE: begin
                        write_beat = 1'b1;
                        pix_cnt_d  = pix_next;
                        if (pix_next == frame_size_q) begin
                            frame_inc = 2'd1;
                            if (in_eop) begin
                                state_d = ST_IDLE;
                            end else begin
                                long_inc = 1'b1;
                                state_d  = ST_DRAIN;
                            end
                        end else if (in_eop) begin
                            short_inc = 2'd1;
                            frame_inc = 2'd1;
                            state_d   = ST_IDLE;
                        end
                    end
                    ST_DRAIN: begin
                        if (in_eop) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: begin
                        // Stray beat outside a frame: dropped silently.
                    end
                endcase
            end
        end
    end

    // Counter updates and the frame-limit stop. The limit is compared every
    // cycle so a num_frame lowered mid-run still stops the block.
    always_comb begin
        frame_cnt_d = frame_cnt_q + {9'd0, frame_inc};
        short_err_d = sat_add8(short_err_q, short_inc);
        long_err_d  = sat_add8(long_err_q, {1'b0, long_inc});
        done_d      = done_q;
        if (state_q == ST_DONE) begin
            done_d = 1'b1;
        end else if ((num_frame != 11'd0) && (frame_cnt_d >= num_frame)) begin
            done_d = 1'b1;
        end
    end

    // State and counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pix_cnt_q    <= '0;
            frame_size_q <= '0;
            frame_cnt_q  <= '0;
            short_err_q  <= '0;
            long_err_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q      <= done_d ? ST_DONE : state_d;
            pix_cnt_q    <= pix_cnt_d;
            frame_size_q <= frame_size_d;
            frame_cnt_q  <= frame_cnt_d;
            short_err_q  <= short_err_d;
            long_err_q   <= long_err_d;
            done_q       <= done_d;
        end
    end

    assign frame_cnt     = frame_cnt_q;
    assign short_err_cnt = short_err_q;
    assign long_err_cnt  = long_err_q;
    assign done          = done_q;

endmodule

// File: tb/tb_frame_fifo_feeder.sv
// Self-checking bench for frame_fifo_feeder: a table of per-beat vectors with
// hand-computed expectations, plus hand-written sequences for back-pressure,
// the frame limit and reset in mid-frame.
module tb_frame_fifo_feeder;

    localparam int DW = 24;

    logic          clock = 1'b0;
    logic          reset;
    logic [10:0]   width, height, num_frame;
    logic          in_valid, in_ready, in_sop, in_eop;
    logic [DW-1:0] in_data;
    logic          fifo_wrreq, fifo_full;
    logic [DW-1:0] fifo_data;
    logic [10:0]   frame_cnt;
    logic [7:0]    short_err_cnt, long_err_cnt;
    logic          done;

    int checks   = 0;
    int failures = 0;

    frame_fifo_feeder #(.DWIDTH(DW)) dut (
        .clock         (clock),
        .reset         (reset),
        .width         (width),
        .height        (height),
        .num_frame     (num_frame),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_sop        (in_sop),
        .in_eop        (in_eop),
        .fifo_wrreq    (fifo_wrreq),
        .fifo_data     (fifo_data),
        .fifo_full     (fifo_full),
        .frame_cnt     (frame_cnt),
        .short_err_cnt (short_err_cnt),
        .long_err_cnt  (long_err_cnt),
        .done          (done)
    );

    always #5 clock = ~clock;

    // Captures every FIFO write in order.
    logic [DW-1:0] wr_log[$];
    always @(posedge clock) begin
        if (fifo_wrreq === 1'b1) wr_log.push_back(fifo_data);
    end

    typedef struct {
        logic          v, sop, eop, full;
        logic [10:0]   w, h;
        logic [DW-1:0] d;
        logic          exp_rdy, exp_wr;
        logic [10:0]   exp_frames;
        logic [7:0]    exp_short, exp_long;
    } vec_t;

    vec_t          tbl[$];
    logic [10:0]   cur_w, cur_h;
    logic [DW-1:0] next_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic v, input logic sop, input logic eop, input logic full,
                       input logic rdy, input logic wr, input int f, input int s, input int l);
        vec_t e;
        e.v = v; e.sop = sop; e.eop = eop; e.full = full;
        e.w = cur_w; e.h = cur_h; e.d = next_d;
        e.exp_rdy = rdy; e.exp_wr = wr;
        e.exp_frames = 11'(f); e.exp_short = 8'(s); e.exp_long = 8'(l);
        next_d = next_d + 24'd1;
        tbl.push_back(e);
    endtask

    // Drives one beat at posedge+1 and advances to the next posedge+1.
    task automatic beat(input logic v, input logic sop, input logic eop, input logic [DW-1:0] d);
        in_valid = v; in_sop = sop; in_eop = eop; in_data = d;
        @(posedge clock); #1;
    endtask

    // Reset with valid input present; leaves time at posedge+1 after release.
    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b0;
        fifo_full = 1'b0; in_data = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_wrreq", 32'(fifo_wrreq), 32'd0);
        in_valid = 1'b0; in_sop = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check("rst_ready_after", 32'(in_ready), 32'd1);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_short", 32'(short_err_cnt), 32'd0);
        check("rst_long", 32'(long_err_cnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clock); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int n_wr;
        int exp_total;
        logic accepted;
        int budget;

        reset = 1'b1; width = 11'd4; height = 11'd2; num_frame = 11'd2;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0; fifo_full = 1'b0;

        // ---------------- Two clean 4x2 frames with random valid and a stall
        do_reset();
        base = wr_log.size();
        for (int p = 0; p < 16; p++) begin
            if (p == 3) begin
                for (int c = 0; c < 5; c++) begin
                    in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b0;
                    in_data = 24'hA00000 + 24'(p); fifo_full = 1'b1;
                    #3;
                    check("stall_ready", 32'(in_ready), 32'd0);
                    check("stall_wrreq", 32'(fifo_wrreq), 32'd0);
                    @(posedge clock); #1;
                end
                fifo_full = 1'b0;
            end
            accepted = 1'b0;
            budget = 0;
            while (!accepted && budget < 50) begin
                in_valid = (budget >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
                in_sop = (p % 8 == 0);
                in_eop = (p % 8 == 7);
                in_data = 24'hA00000 + 24'(p);
                #3;
                accepted = in_valid && in_ready;
                @(posedge clock); #1;
                budget++;
            end
            check("a_accept", 32'(accepted), 32'd1);
            if (p == 7) begin
                check("a_frame1_cnt", 32'(frame_cnt), 32'd1);
                check("a_frame1_done", 32'(done), 32'd0);
            end
        end
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        n_wr = wr_log.size() - base;
        check("a_writes", 32'(n_wr), 32'd16);
        for (int i = 0; i < 16 && i < n_wr; i++)
            check("a_data", 32'(wr_log[base + i]), 32'(24'hA00000 + 24'(i)));
        check("a_frame_cnt", 32'(frame_cnt), 32'd2);
        check("a_done", 32'(done), 32'd1);
        check("a_short", 32'(short_err_cnt), 32'd0);
        check("a_long", 32'(long_err_cnt), 32'd0);
        in_valid = 1'b1; in_sop = 1'b1;
        #3;
        check("a_ready_after_done", 32'(in_ready), 32'd0);
        check("a_no_write_after_done", 32'(fifo_wrreq), 32'd0);
        @(posedge clock); #1;

        // ---------------- Table-driven sequence, unlimited frames
        next_d = 24'h300000;
        cur_w = 11'd3; cur_h = 11'd3;
        // short frame: EOP on pixel 5
        add(1,1,0,0, 1,1, 0,0,0);
        for (int i = 0; i < 3; i++) add(1,0,0,0, 1,1, 0,0,0);
        add(1,0,1,0, 1,1, 1,1,0);
        // stray beat in IDLE is dropped; full blocks ready in IDLE
        add(1,0,0,0, 1,0, 1,1,0);
        add(0,0,0,1, 0,0, 1,1,0);
        // clean 9-pixel frame
        add(1,1,0,0, 1,1, 1,1,0);
        for (int i = 0; i < 7; i++) add(1,0,0,0, 1,1, 1,1,0);
        add(1,0,1,0, 1,1, 2,1,0);
        // 12-pixel frame: 9 written, 3 drained (full ignored while draining)
        add(1,1,0,0, 1,1, 2,1,0);
        for (int i = 0; i < 7; i++) add(1,0,0,0, 1,1, 2,1,0);
        add(1,0,0,0, 1,1, 3,1,1);
        add(1,0,0,0, 1,0, 3,1,1);
        add(1,0,0,1, 1,0, 3,1,1);
        add(1,0,1,0, 1,0, 3,1,1);
        add(0,0,0,1, 0,0, 3,1,1);
        // SOF at pixel 4 restarts the frame; 8 more pixels complete it
        add(1,1,0,0, 1,1, 3,1,1);
        for (int i = 0; i < 2; i++) add(1,0,0,0, 1,1, 3,1,1);
        add(1,1,0,0, 1,1, 4,2,1);
        for (int i = 0; i < 7; i++) add(1,0,0,0, 1,1, 4,2,1);
        add(1,0,1,0, 1,1, 5,2,1);
        // zero-sized frames
        cur_w = 11'd0;
        add(1,1,0,0, 1,0, 6,2,2);
        add(1,0,0,1, 1,0, 6,2,2);
        add(1,0,1,0, 1,0, 6,2,2);
        add(1,1,1,0, 1,0, 7,2,3);
        add(0,0,0,1, 0,0, 7,2,3);
        // one-pixel frames: SOF+EOP good; SOF alone overruns into DRAIN
        cur_w = 11'd1; cur_h = 11'd1;
        add(1,1,1,0, 1,1, 8,2,3);
        add(1,1,0,0, 1,1, 9,2,4);
        // SOF while draining starts a frame without a short error
        cur_w = 11'd3; cur_h = 11'd3;
        add(1,1,0,0, 1,1, 9,2,4);
        for (int i = 0; i < 7; i++) add(1,0,0,0, 1,1, 9,2,4);
        add(1,0,1,0, 1,1, 10,2,4);
        // SOF+EOP on a 3x3 frame is short
        add(1,1,1,0, 1,1, 11,3,4);

        num_frame = 11'd0;
        do_reset();
        base = wr_log.size();
        exp_total = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            in_valid = tbl[i].v; in_sop = tbl[i].sop; in_eop = tbl[i].eop;
            fifo_full = tbl[i].full; in_data = tbl[i].d;
            width = tbl[i].w; height = tbl[i].h;
            if (tbl[i].exp_wr) exp_total++;
            #3;
            check($sformatf("v%0d_ready", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
            check($sformatf("v%0d_wrreq", i), 32'(fifo_wrreq), 32'(tbl[i].exp_wr));
            if (tbl[i].exp_wr)
                check($sformatf("v%0d_data", i), 32'(fifo_data), 32'(tbl[i].d));
            @(posedge clock); #1;
            check($sformatf("v%0d_frames", i), 32'(frame_cnt), 32'(tbl[i].exp_frames));
            check($sformatf("v%0d_short", i), 32'(short_err_cnt), 32'(tbl[i].exp_short));
            check($sformatf("v%0d_long", i), 32'(long_err_cnt), 32'(tbl[i].exp_long));
        end
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; fifo_full = 1'b0;
        check("tbl_total_writes", 32'(wr_log.size() - base), 32'(exp_total));

        // ---------------- Lowering num_frame below frame_cnt stops the block
        num_frame = 11'd5;
        #3;
        check("nf_done_before", 32'(done), 32'd0);
        check("nf_ready_before", 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        check("nf_done_after", 32'(done), 32'd1);
        check("nf_ready_after", 32'(in_ready), 32'd0);
        check("nf_frames_held", 32'(frame_cnt), 32'd11);

        // ---------------- Reset during pixel 3 of a frame
        num_frame = 11'd0; width = 11'd3; height = 11'd3;
        do_reset();
        beat(1, 1, 0, 24'h000001);
        beat(1, 0, 1, 24'h000002);
        check("mr_short_pre", 32'(short_err_cnt), 32'd1);
        check("mr_frames_pre", 32'(frame_cnt), 32'd1);
        beat(1, 1, 0, 24'h000011);
        beat(1, 0, 0, 24'h000012);
        in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b0; in_data = 24'h000013;
        #2;
        reset = 1'b1;
        #1;
        check("mr_ready_in_reset", 32'(in_ready), 32'd0);
        @(posedge clock); #1;
        check("mr_frames_cleared", 32'(frame_cnt), 32'd0);
        check("mr_short_cleared", 32'(short_err_cnt), 32'd0);
        in_valid = 1'b0;
        reset = 1'b0;
        base = wr_log.size();
        beat(1, 0, 0, 24'h0000EE);
        for (int i = 0; i < 9; i++) beat(1, i == 0, i == 8, 24'h000100 + 24'(i));
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        n_wr = wr_log.size() - base;
        check("mr_writes", 32'(n_wr), 32'd9);
        if (n_wr > 0) check("mr_first_data", 32'(wr_log[base]), 32'h000100);
        check("mr_frame_cnt", 32'(frame_cnt), 32'd1);
        check("mr_short", 32'(short_err_cnt), 32'd0);
        check("mr_long", 32'(long_err_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_fifo_feeder.md
# frame_fifo_feeder

Upstream neighbour of the testbench image writer in the VIP core output path. Accepts a framed RGB pixel stream (valid/ready with start/end-of-frame markers) from the last processing stage and pushes exactly-sized frames into the output FIFO that the writer drains. It checks each frame against the configured `width × height`, truncates long frames and counts short ones. It stops accepting input after `num_frame` frames.

## Interface
Parameters:
- `DWIDTH`, default 24: pixel width, packed RGB as {R[23:16], G[15:8], B[7:0]}.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `width`  in  11  frame width in pixels; sampled on each accepted start-of-frame (SOF) beat.
- `height`  in  11  frame height in lines; sampled with `width`.
- `num_frame`  in  11  frames to forward before stopping; 0 means unlimited.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  block can take a beat.
- `in_data`  in  DWIDTH  pixel.
- `in_sop`  in  1  first pixel of a frame.
- `in_eop`  in  1  last pixel of a frame.
- `fifo_wrreq`  out  1  FIFO write strobe.
- `fifo_data`  out  DWIDTH  FIFO write data.
- `fifo_full`  in  1  FIFO full.
- `frame_cnt`  out  11  frames terminated since reset.
- `short_err_cnt`  out  8  frames that ended early; saturates at 255.
- `long_err_cnt`  out  8  frames that overran or had zero size; saturates at 255.
- `done`  out  1  sticky; `num_frame` frames terminated.

## Operation
- Accept = `in_valid && in_ready`.
- `frame_size` = `width*height`: 22-bit unsigned, latched on each accepted SOF.
- `pix_cnt`: 22 bits.
- States:
  - IDLE:
    - `in_ready = !fifo_full`.
    - Accepted beat without SOF: discarded, no counter change.
    - Accepted SOF with `frame_size==0`: discarded; `long_err_cnt+1`, `frame_cnt+1`; go to DRAIN unless `in_eop` is also set.
    - Accepted SOF with `frame_size>0`: written; `pix_cnt=1`; go to ACTIVE, or apply the end-of-frame rules below if this is the last pixel.
  - ACTIVE:
    - `in_ready = !fifo_full`. Every accepted beat is written; `pix_cnt+1`.
    - Beat with SOF: `short_err_cnt+1`, `frame_cnt+1` (previous frame closed); the beat starts a new frame exactly as in IDLE.
    - Beat with EOP and `pix_cnt+1 < frame_size`: `short_err_cnt+1`, `frame_cnt+1`, go to IDLE. No padding is added.
    - Beat reaching `pix_cnt+1 == frame_size` with EOP: good frame; `frame_cnt+1`, go to IDLE.
    - Beat reaching `pix_cnt+1 == frame_size` without EOP: written; `long_err_cnt+1`, `frame_cnt+1`, go to DRAIN.
  - DRAIN:
    - `in_ready=1`, nothing written.
    - Beat with EOP and no SOF: go to IDLE.
    - Beat with SOF: handled as an IDLE SOF.
  - DONE:
    - Entered on the cycle `frame_cnt` becomes equal to `num_frame` (`num_frame≠0`).
    - `in_ready=0`, `done=1`, no writes until reset.
- `fifo_wrreq` = accept && beat written; `fifo_data = in_data` (combinational pass-through). A write never occurs while `fifo_full=1`.
- SOF+EOP on one beat with `frame_size==1`: good frame, stay in IDLE.
- `num_frame` changing mid-run: compared each cycle. If `frame_cnt ≥ num_frame ≠ 0` → DONE.
- Error counters saturate; `frame_cnt` wraps at 2047.

## Timing
- Reset: state IDLE; all counters 0; `done=0`; `in_ready` follows `!fifo_full` immediately after reset release, 0 during reset; `fifo_wrreq=0`.
- Zero-latency path: input beat to FIFO write in the same cycle. Back-pressure is combinational from `fifo_full`.
- All counter and state updates take effect on the clock edge of the accepting beat. `done` rises on the edge that terminates the `num_frame`-th frame.
- Reset mid-frame: all state cleared; FIFO contents untouched. The next frame must start with SOF.

## Test plan
- `width=4`, `height=2`, `num_frame=2`, two clean 8-pixel frames, random `in_valid` → 16 writes with data in order; `frame_cnt=2`; `done=1`; errors 0; `in_ready=0` afterwards.
- Hold `fifo_full=1` for 5 cycles mid-frame with `in_valid=1` → `in_ready=0` and no `fifo_wrreq` during those cycles; no pixel lost or duplicated.
- 3×3 config, frame with EOP on the 5th pixel → 5 writes; `short_err_cnt=1`; `frame_cnt=1`; next SOF frame is accepted normally.
- 3×3 config, 12-pixel frame → 9 writes, 3 beats drained; `long_err_cnt=1`; state IDLE after EOP.
- SOF arriving at pixel 4 of a 3×3 frame → `short_err_cnt=1`; new frame begins with that pixel written; `pix_cnt=1`.
- Assert reset during pixel 3, release, send a full frame → counters restart at 0; exactly 9 writes after release; `frame_cnt=1`.
